// File: rtl/uart_rx_periph.sv
// 6502-bus-mapped 8N1 UART receiver with a small receive FIFO.
// Optional macro UART_RX_IRQ_EN enables the registered interrupt output and CTRL bit1.
module uart_rx_periph #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_phi2,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_rw,
    input  logic       i_en,
    output logic [7:0] o_data,
    input  logic       i_rx,
    output logic       o_irq
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus commit happens on the i_clk cycle that sees phi2 fall
    logic phi2_q;
    logic commit, rd_commit, wr_commit;

    assign commit    = phi2_q & ~i_phi2 & i_en;
    assign rd_commit = commit & i_rw;
    assign wr_commit = commit & ~i_rw;

    logic [15:0] div_q;
    logic        rx_en_q;
    logic        ctrl_irq_en;

    logic rx_meta_q, rx_s_q, rx_prev_q;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] wdiv_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovr_q, ferr_q;

    logic [15:0] div_eff;
    logic        push, ferr_set, pop, full, avail, wr_ok, ovr_set, sts_wr;

    assign div_eff  = (div_q < 16'd3) ? 16'd3 : div_q;
    assign push     = (state_q == S_STOP) && (cnt_q == 16'd0) && rx_en_q && rx_s_q;
    assign ferr_set = (state_q == S_STOP) && (cnt_q == 16'd0) && rx_en_q && !rx_s_q;
    assign avail    = (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = rd_commit && (i_addr == 4'd0) && avail;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign wr_ok    = push && (!full || pop);
    assign ovr_set  = push && full && !pop;
    assign sts_wr   = wr_commit && (i_addr == 4'd1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phi2_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            phi2_q    <= i_phi2;
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_q   <= DEFAULT_DIV;
            rx_en_q <= 1'b0;
        end else if (wr_commit) begin
            case (i_addr)
                4'd2:    div_q[7:0]  <= i_data;
                4'd3:    div_q[15:8] <= i_data;
                4'd4:    rx_en_q     <= i_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            wdiv_q    <= 16'd3;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
        end else if (state_q != S_IDLE && !rx_en_q) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_en_q && rx_prev_q && !rx_s_q) begin
                        wdiv_q  <= div_eff;
                        cnt_q   <= div_eff >> 1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (!rx_s_q) begin
                        cnt_q     <= wdiv_q;
                        bit_idx_q <= 3'd0;
                        state_q   <= S_DATA;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        shreg_q   <= {rx_s_q, shreg_q[7:1]};
                        cnt_q     <= wdiv_q;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q != 16'd0) cnt_q   <= cnt_q - 16'd1;
                    else                state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            // Set beats a same-cycle write-1-clear
            ovr_q  <= ovr_set  | (ovr_q  & ~(sts_wr & i_data[2]));
            ferr_q <= ferr_set | (ferr_q & ~(sts_wr & i_data[3]));
        end
    end

`ifdef UART_RX_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_commit && i_addr == 4'd4) irq_en_q <= i_data[1];
            irq_q <= irq_en_q & (avail | ovr_q | ferr_q);
        end
    end

    assign ctrl_irq_en = irq_en_q;
    assign o_irq       = irq_q;
`else
    assign ctrl_irq_en = 1'b0;
    assign o_irq       = 1'b0;
`endif

    always_comb begin
        o_data = 8'h00;
        if (i_en && i_rw) begin
            case (i_addr)
                4'd0:    o_data = avail ? mem_q[rd_ptr_q] : 8'h00;
                4'd1:    o_data = {o_irq, 3'b000, ferr_q, ovr_q, full, avail};
                4'd2:    o_data = div_q[7:0];
                4'd3:    o_data = div_q[15:8];
                4'd4:    o_data = {6'b0, ctrl_irq_en, rx_en_q};
                default: o_data = 8'h00;
            endcase
        end
    end
endmodule

// File: doc/uart_rx_periph.md
Name: uart_rx_periph

Overview:
- 6502-bus-mapped UART receiver. Consumes the serial line that the GPIO mux delivers on o_uart0_rx.
- Deserialises 8N1 frames at a programmable bit period and buffers received bytes in a small FIFO.
- The CPU reads the bytes out through a 16-entry register window, on the same bus signals the GPIO block uses.
- Optionally raises an interrupt when data is waiting.

Parameters:
- FIFO_DEPTH, 8: receive FIFO entries; power of two, 2..32.
- DEFAULT_DIV, 16'd103: reset value of the divisor. Bit period = DIV+1 i_clk cycles.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_phi2  in  1  6502 phase-2 clock level, sampled in the i_clk domain
- i_addr  in  4  register select
- i_data  in  8  write data
- i_rw  in  1  1 = read, 0 = write
- i_en  in  1  chip select
- o_data  out  8  read data
- i_rx  in  1  serial input; idle high
- o_irq  out  1  interrupt request, active high

Behaviour:
- Reset values:
  - FIFO empty; flags 0; DIV = DEFAULT_DIV; CTRL = 0; receiver state IDLE.
  - o_data = 0x00; o_irq = 0.
  - i_rx synchroniser flops reset to 1.
- Bus timing:
  - The i_phi2 falling edge is detected on i_clk: phi2_q = 1 and i_phi2 = 0.
  - A bus "commit" occurs on that cycle when i_en = 1.
  - Writes, pops and flag clears happen only on a commit.
  - o_data is combinational: the register selected by i_addr when i_en & i_rw, otherwise 0x00.
- Register map:
  - 0 DATA (R): FIFO head. A read commit pops one entry. Reads 0x00 when empty, with no pointer change.
  - 1 STATUS (R): bit0 rx_avail (count != 0), bit1 full, bit2 overrun (sticky), bit3 framing_err (sticky), bit7 o_irq. Other bits 0.
  - 1 STATUS (W): write 1 to bit2 or bit3 clears that flag; write 0 leaves it.
  - 2 DIV_LO (R/W), 3 DIV_HI (R/W).
  - 4 CTRL (R/W): bit0 rx_enable, bit1 irq_enable.
  - 5..15: read 0x00; writes ignored.
- Input conditioning: i_rx passes through a 2-flop synchroniser before use (rx_s).
- Receiver FSM:
  - IDLE: when rx_enable = 1 and rx_s falls 1->0, latch DIV into the working divisor, load the counter with DIV>>1, go to START.
  - START: counter reaches 0 -> sample rx_s.
    - Low: reload counter with DIV, bit index = 0, go to DATA.
    - High: false start, return to IDLE with no flag.
  - DATA: each counter expiry shifts rx_s into the shift register, LSB first, and reloads the counter. After bit 7, go to STOP.
  - STOP: counter expiry samples rx_s.
    - High: push the byte.
    - Low: discard the byte, set framing_err.
    - In both cases return to IDLE; the next start edge may be detected on the following cycle.
- Clearing rx_enable mid-frame aborts to IDLE next cycle; the partial byte is discarded.
- DIV written mid-frame takes effect at the next start edge. DIV values below 3 are treated as 3.
- FIFO:
  - Push when full: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop on the same cycle: both take effect, count unchanged. If the FIFO was full, the push succeeds and no overrun is set.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
  - Latency: the pushed byte is visible at DATA and rx_avail on the cycle after the STOP sample.
- Flag priority: if a set and a write-1-clear of the same flag occur on the same cycle, the set wins.

Optional Feature:
- Macro: UART_RX_IRQ_EN.
- Defined:
  - o_irq is a registered output = irq_enable & (rx_avail | overrun | framing_err).
  - It updates the cycle after any contributing change.
- Undefined:
  - o_irq is tied 0.
  - CTRL bit1 is not stored: it reads 0 and writes to it are ignored.
  - STATUS bit7 reads 0.

Test Plan:
- Reset, then read STATUS, DIV_LO, DIV_HI -> 0x00, 0x67, 0x00; o_irq = 0.
- DIV = 9, CTRL = 0x01, drive frame 0xA5 (10 clk/bit) -> STATUS bit0 = 1 one cycle after the stop sample. DATA read returns 0xA5; STATUS then reads 0x00.
- DIV = 9, send 9 bytes 0x01..0x09 with FIFO_DEPTH = 8 and no reads -> STATUS = 0x07. Eight reads return 0x01..0x08; a ninth read returns 0x00. Write STATUS = 0x04 -> overrun clears.
- Frame 0x3C with stop bit driven low -> no push, STATUS bit3 = 1, rx_avail = 0. A 4-clock low glitch on idle line -> false start, no flags.
- Byte arrives while FIFO holds 1 entry, with DATA read committing on the push cycle -> old byte returned, count stays 1, new byte readable next.
- With UART_RX_IRQ_EN defined, CTRL = 0x03, receive 0x55 -> o_irq = 1 the cycle after rx_avail rises; read DATA -> o_irq = 0 the following cycle. With the macro undefined, o_irq stays 0 and CTRL reads 0x01.
